// File: rtl/reg_width_downsizer.sv
// reg_width_downsizer
//   Register-bus data-width converter. One wide request on the slave port is
//   serialised into Ratio = WideDataWidth/NarrowDataWidth narrow beats on the
//   master port. Only one transaction is in flight at a time.
//
//   Optional feature macro: REG_DWN_SKIP_EMPTY_EN
//     When defined, a write beat whose strobe slice is all-zero is not issued.
//     It takes one ISSUE cycle with m_req_valid_o low, and then the beat index
//     advances. Reads are never skipped.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   s_req_*_i              wide request (valid, addr, write, wdata, wstrb)
//   s_rsp_ready_o          one-cycle completion pulse
//   s_rsp_rdata_o/error_o  assembled read data / OR of beat errors; these hold
//                          their values until the next request is captured
//   m_req_*_o              narrow beat request (valid, addr, write, wdata, wstrb)
//   m_rsp_*_i              narrow beat response (ready, rdata, error)
module reg_width_downsizer #(
   parameter int unsigned AddrWidth       = 32,
   parameter int unsigned WideDataWidth   = 64,
   parameter int unsigned NarrowDataWidth = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         s_req_valid_i,
   input  logic [AddrWidth-1:0]         s_req_addr_i,
   input  logic                         s_req_write_i,
   input  logic [WideDataWidth-1:0]     s_req_wdata_i,
   input  logic [WideDataWidth/8-1:0]   s_req_wstrb_i,
   output logic                         s_rsp_ready_o,
   output logic [WideDataWidth-1:0]     s_rsp_rdata_o,
   output logic                         s_rsp_error_o,
   output logic                         m_req_valid_o,
   output logic [AddrWidth-1:0]         m_req_addr_o,
   output logic                         m_req_write_o,
   output logic [NarrowDataWidth-1:0]   m_req_wdata_o,
   output logic [NarrowDataWidth/8-1:0] m_req_wstrb_o,
   input  logic                         m_rsp_ready_i,
   input  logic [NarrowDataWidth-1:0]   m_rsp_rdata_i,
   input  logic                         m_rsp_error_i
);

   localparam int unsigned Ratio = WideDataWidth / NarrowDataWidth;
   localparam int unsigned WB    = WideDataWidth / 8;
   localparam int unsigned NB    = NarrowDataWidth / 8;
   localparam int unsigned IdxW  = (Ratio > 1) ? $clog2(Ratio) : 1;

   localparam logic [IdxW-1:0]      LastIdx    = IdxW'(Ratio - 1);
   localparam logic [AddrWidth-1:0] AlignMask  = ~AddrWidth'(WB - 1);
   localparam logic [AddrWidth-1:0] BeatStride = AddrWidth'(NB);

   typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

   state_e                     state_q, state_d;
   logic [IdxW-1:0]            idx_q;
   logic [AddrWidth-1:0]       base_q;
   logic                       write_q;
   logic [WideDataWidth-1:0]   wdata_q;
   logic [WB-1:0]              wstrb_q;
   logic [WideDataWidth-1:0]   rdata_q;
   logic                       error_q;

   logic [NarrowDataWidth-1:0] wdata_slice;
   logic [NB-1:0]              wstrb_slice;
   logic                       skip_beat;
   logic                       beat_done;
   logic                       capture;

   assign wdata_slice = wdata_q[idx_q*NarrowDataWidth +: NarrowDataWidth];
   assign wstrb_slice = wstrb_q[idx_q*NB +: NB];

`ifdef REG_DWN_SKIP_EMPTY_EN
   assign skip_beat = (state_q == StIssue) && write_q && (wstrb_slice == '0);
`else
   assign skip_beat = 1'b0;
`endif

   assign s_rsp_rdata_o = rdata_q;
   assign s_rsp_error_o = error_q;

   // Next-state and outputs. Master outputs are forced to zero outside ISSUE.
   always_comb begin
      state_d       = state_q;
      capture       = 1'b0;
      beat_done     = 1'b0;
      s_rsp_ready_o = 1'b0;
      m_req_valid_o = 1'b0;
      m_req_addr_o  = '0;
      m_req_write_o = 1'b0;
      m_req_wdata_o = '0;
      m_req_wstrb_o = '0;
      unique case (state_q)
         StIdle: begin
            if (s_req_valid_i) begin
               capture = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            m_req_valid_o = ~skip_beat;
            m_req_addr_o  = base_q + AddrWidth'(idx_q) * BeatStride;
            m_req_write_o = write_q;
            m_req_wdata_o = wdata_slice;
            m_req_wstrb_o = write_q ? wstrb_slice : '0;
            // A skipped beat retires without waiting for the master.
            beat_done     = skip_beat | m_rsp_ready_i;
            if (beat_done && (idx_q == LastIdx)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            s_rsp_ready_o = 1'b1;
            state_d       = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         idx_q   <= '0;
         base_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            base_q  <= s_req_addr_i & AlignMask;
            write_q <= s_req_write_i;
            wdata_q <= s_req_wdata_i;
            wstrb_q <= s_req_wstrb_i;
            rdata_q <= '0;
            error_q <= 1'b0;
            idx_q   <= '0;
         end else if (beat_done) begin
            if (!skip_beat) begin
               if (!write_q) begin
                  rdata_q[idx_q*NarrowDataWidth +: NarrowDataWidth] <= m_rsp_rdata_i;
               end
               // Errors accumulate; remaining beats are still issued.
               error_q <= error_q | m_rsp_error_i;
            end
            if (idx_q != LastIdx) begin
               idx_q <= idx_q + IdxW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_width_downsizer.sv
// tb_reg_width_downsizer
//   Self-checking bench for reg_width_downsizer at the default 32/64/32 sizing.
//   A transaction-level model derives the expected beat list, response data,
//   error flag and completion cycle from the request and the master behaviour.
module tb_reg_width_downsizer;

   localparam int AW  = 32;
   localparam int WDW = 64;
   localparam int NDW = 32;
   localparam int R   = WDW / NDW;
   localparam int WB  = WDW / 8;
   localparam int NB  = NDW / 8;

`ifdef REG_DWN_SKIP_EMPTY_EN
   localparam bit SkipEn = 1'b1;
`else
   localparam bit SkipEn = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           s_req_valid = 1'b0;
   logic [AW-1:0]  s_req_addr = '0;
   logic           s_req_write = 1'b0;
   logic [WDW-1:0] s_req_wdata = '0;
   logic [WB-1:0]  s_req_wstrb = '0;
   logic           s_rsp_ready;
   logic [WDW-1:0] s_rsp_rdata;
   logic           s_rsp_error;
   logic           m_req_valid;
   logic [AW-1:0]  m_req_addr;
   logic           m_req_write;
   logic [NDW-1:0] m_req_wdata;
   logic [NB-1:0]  m_req_wstrb;
   logic           m_rsp_ready = 1'b0;
   logic [NDW-1:0] m_rsp_rdata = '0;
   logic           m_rsp_error = 1'b0;

   int checks   = 0;
   int failures = 0;

   // Master behaviour per beat index
   int             stall_cfg [R];
   bit             err_cfg   [R];
   logic [NDW-1:0] rd_cfg    [R];
   logic [WDW-1:0] last_exp_rdata;
   logic           last_exp_error;

   always #5 clk = ~clk;

   reg_width_downsizer #(
      .AddrWidth       (AW),
      .WideDataWidth   (WDW),
      .NarrowDataWidth (NDW)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .s_req_valid_i (s_req_valid),
      .s_req_addr_i  (s_req_addr),
      .s_req_write_i (s_req_write),
      .s_req_wdata_i (s_req_wdata),
      .s_req_wstrb_i (s_req_wstrb),
      .s_rsp_ready_o (s_rsp_ready),
      .s_rsp_rdata_o (s_rsp_rdata),
      .s_rsp_error_o (s_rsp_error),
      .m_req_valid_o (m_req_valid),
      .m_req_addr_o  (m_req_addr),
      .m_req_write_o (m_req_write),
      .m_req_wdata_o (m_req_wdata),
      .m_req_wstrb_o (m_req_wstrb),
      .m_rsp_ready_i (m_rsp_ready),
      .m_rsp_rdata_i (m_rsp_rdata),
      .m_rsp_error_i (m_rsp_error)
   );

   task automatic do_reset();
      rst = 1'b1;
      s_req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic cfg_master(input int st0, input int st1, input bit e0, input bit e1,
                             input logic [NDW-1:0] d0, input logic [NDW-1:0] d1);
      stall_cfg[0] = st0; stall_cfg[1] = st1;
      err_cfg[0]   = e0;  err_cfg[1]   = e1;
      rd_cfg[0]    = d0;  rd_cfg[1]    = d1;
   endtask

   // Runs one transaction; cycle 0 is the cycle the request is first presented.
   task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [WDW-1:0] wd,
                          input logic [WB-1:0] ws, input bit hold, input string name);
      int             exp_idx[$];
      int             exp_cyc;
      logic [WDW-1:0] exp_rd;
      logic           exp_err;
      logic [AW-1:0]  base;
      logic [AW-1:0]  ea;
      logic [NDW-1:0] ewd;
      logic [NB-1:0]  ews;
      logic [NB-1:0]  slice;
      int             cur;
      int             stall_left;
      bit             done;

      base    = addr - (addr % WB);
      exp_cyc = 1;
      exp_rd  = '0;
      exp_err = 1'b0;
      for (int i = 0; i < R; i++) begin
         slice = NB'(ws >> (NB * i));
         if (SkipEn && wr && (slice == 0)) begin
            exp_cyc += 1;
         end else begin
            exp_idx.push_back(i);
            exp_cyc += stall_cfg[i] + 1;
            exp_err |= err_cfg[i];
            if (!wr) exp_rd |= WDW'(rd_cfg[i]) << (NDW * i);
         end
      end
      last_exp_rdata = exp_rd;
      last_exp_error = exp_err;

      @(posedge clk);
      #1;
      s_req_valid = 1'b1;
      s_req_addr  = addr;
      s_req_write = wr;
      s_req_wdata = wd;
      s_req_wstrb = ws;
      m_rsp_ready = 1'($urandom_range(0, 1));
      stall_left  = (exp_idx.size() > 0) ? stall_cfg[exp_idx[0]] : 0;
      done        = 1'b0;

      for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
         @(posedge clk);
         #1;
         // Noise on the response lines; only meaningful while a beat is valid.
         m_rsp_ready = 1'($urandom_range(0, 1));
         m_rsp_rdata = $urandom;
         m_rsp_error = 1'($urandom_range(0, 1));
         if (m_req_valid) begin
            if (exp_idx.size() == 0) begin
               checks++; failures++;
               $display("FAIL %s extra_beat cycle=%0d addr=%h", name, cyc, m_req_addr);
            end else begin
               cur = exp_idx[0];
               ea  = base + AW'(NB * cur);
               ewd = NDW'(wd >> (NDW * cur));
               ews = wr ? NB'(ws >> (NB * cur)) : '0;
               checks += 4;
               if (m_req_addr !== ea) begin
                  failures++;
                  $display("FAIL %s beat_addr cycle=%0d got=%h exp=%h", name, cyc, m_req_addr, ea);
               end
               if (m_req_write !== wr) begin
                  failures++;
                  $display("FAIL %s beat_write cycle=%0d got=%b exp=%b", name, cyc, m_req_write, wr);
               end
               if (m_req_wdata !== ewd) begin
                  failures++;
                  $display("FAIL %s beat_wdata cycle=%0d got=%h exp=%h", name, cyc, m_req_wdata, ewd);
               end
               if (m_req_wstrb !== ews) begin
                  failures++;
                  $display("FAIL %s beat_wstrb cycle=%0d got=%h exp=%h", name, cyc, m_req_wstrb, ews);
               end
               if (stall_left > 0) begin
                  m_rsp_ready = 1'b0;
                  stall_left--;
               end else begin
                  m_rsp_ready = 1'b1;
                  m_rsp_rdata = rd_cfg[cur];
                  m_rsp_error = err_cfg[cur];
                  void'(exp_idx.pop_front());
                  if (exp_idx.size() > 0) stall_left = stall_cfg[exp_idx[0]];
               end
            end
         end
         if (s_rsp_ready) begin
            done = 1'b1;
            checks += 4;
            if (cyc != exp_cyc) begin
               failures++;
               $display("FAIL %s ready_cycle got=%0d exp=%0d", name, cyc, exp_cyc);
            end
            if (s_rsp_rdata !== exp_rd) begin
               failures++;
               $display("FAIL %s rdata got=%h exp=%h", name, s_rsp_rdata, exp_rd);
            end
            if (s_rsp_error !== exp_err) begin
               failures++;
               $display("FAIL %s error got=%b exp=%b", name, s_rsp_error, exp_err);
            end
            if (exp_idx.size() != 0) begin
               failures++;
               $display("FAIL %s missing_beats got=%0d exp=0", name, exp_idx.size());
            end
            if (!hold) s_req_valid = 1'b0;
         end
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL %s timeout no_ready_within=60 exp_cycle=%0d", name, exp_cyc);
         do_reset();
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({s_rsp_ready, s_rsp_rdata, s_rsp_error, m_req_valid, m_req_addr, m_req_write,
           m_req_wdata, m_req_wstrb} !== '0) begin
         failures++;
         $display("FAIL %s outputs_zero got rdy=%b rd=%h err=%b mv=%b ma=%h mw=%b md=%h ms=%h exp=all0",
                  name, s_rsp_ready, s_rsp_rdata, s_rsp_error, m_req_valid, m_req_addr,
                  m_req_write, m_req_wdata, m_req_wstrb);
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_all_zero("reset");
      // Master ready with no beat pending must not move the block.
      m_rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      m_rsp_ready = 1'b0;
      check_all_zero("idle_ready_ignored");
   endtask

   task automatic test_read_basic();
      cfg_master(0, 0, 0, 0, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
      run_txn(32'h100, 1'b0, '0, '0, 1'b0, "read_basic");
      checks++;
      if (64'hBBBB_BBBB_AAAA_AAAA !== last_exp_rdata) begin
         failures++;
         $display("FAIL read_basic model_rdata got=%h exp=bbbbbbbbaaaaaaaa", last_exp_rdata);
      end
      @(posedge clk);
      #1;
      checks++;
      if (s_rsp_rdata !== 64'hBBBB_BBBB_AAAA_AAAA || s_rsp_ready !== 1'b0) begin
         failures++;
         $display("FAIL read_hold got rd=%h rdy=%b exp rd=bbbbbbbbaaaaaaaa rdy=0",
                  s_rsp_rdata, s_rsp_ready);
      end
   endtask

   task automatic test_write_misaligned();
      cfg_master(0, 1, 0, 0, '0, '0);
      run_txn(32'h10C, 1'b1, 64'h1122_3344_5566_7788, 8'hF0, 1'b0, "write_misaligned");
   endtask

   task automatic test_stall_error();
      cfg_master(3, 0, 1, 0, 32'h1234_5678, 32'h9ABC_DEF0);
      run_txn(32'h200, 1'b0, '0, '0, 1'b0, "stall_error");
   endtask

   task automatic test_zero_strobe();
      cfg_master(0, 0, 1, 1, '0, '0);
      run_txn(32'h300, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h00, 1'b0, "zero_strobe");
   endtask

   task automatic test_reset_mid();
      bit seen_ready;
      cfg_master(0, 0, 0, 0, 32'h5555_0000, 32'h6666_1111);
      @(posedge clk);
      #1;
      s_req_valid = 1'b1;
      s_req_addr  = 32'h400;
      s_req_write = 1'b0;
      for (int cyc = 1; cyc <= 2; cyc++) begin
         @(posedge clk);
         #1;
         checks++;
         if (m_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid beat_valid cycle=%0d got=%b exp=1", cyc, m_req_valid);
         end
         m_rsp_ready = 1'b1;
         m_rsp_rdata = rd_cfg[cyc-1];
         m_rsp_error = 1'b0;
         if (cyc == 2) begin
            rst = 1'b1;
            s_req_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_rsp_ready = 1'b0;
      check_all_zero("reset_mid");
      seen_ready = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (s_rsp_ready) seen_ready = 1'b1;
      end
      checks++;
      if (seen_ready) begin
         failures++;
         $display("FAIL reset_mid stray_ready got=1 exp=0");
      end
      cfg_master(0, 0, 0, 0, 32'h0BAD_F00D, 32'h7777_8888);
      run_txn(32'h404, 1'b0, '0, '0, 1'b0, "after_reset_read");
   endtask

   task automatic test_back_to_back();
      cfg_master(0, 0, 0, 0, 32'h0101_0101, 32'h0202_0202);
      run_txn(32'h500, 1'b0, '0, '0, 1'b1, "b2b_first");
      cfg_master(0, 0, 0, 1, 32'h0303_0303, 32'h0404_0404);
      run_txn(32'h508, 1'b0, '0, '0, 1'b0, "b2b_second");
   endtask

   task automatic test_random();
      logic [AW-1:0]  a;
      logic           w;
      logic [WDW-1:0] d;
      logic [WB-1:0]  s;
      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         if (n % 8 == 0) a = 32'hFFFF_FFF8 | AW'($urandom_range(0, 7));
         w = 1'($urandom_range(0, 1));
         d = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       s = 8'h00;
            1:       s = 8'h0F;
            2:       s = 8'hF0;
            default: s = 8'($urandom);
         endcase
         for (int i = 0; i < R; i++) begin
            stall_cfg[i] = $urandom_range(0, 2);
            err_cfg[i]   = ($urandom_range(0, 3) == 0);
            rd_cfg[i]    = $urandom;
         end
         run_txn(a, w, d, s, 1'($urandom_range(0, 1)), "random");
      end
      s_req_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_write_misaligned();
      test_stall_error();
      test_zero_strobe();
      test_reset_mid();
      test_back_to_back();
      test_random();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
